// File: rtl/seq_det_if.sv
// Serial data link into the pattern detector.
// There is no valid/ready handshake on this link: the detector
// consumes x on every rising clk edge and z is a one-cycle strobe
// with no backpressure. The source (master) drives x; the detector
// (slave) returns z.
interface seq_det_if;
    logic x;
    logic z;

    modport master (
        output x,
        input  z
    );

    modport slave (
        input  x,
        output z
    );
endinterface

// File: rtl/seq_det.sv
// Serial bit-pattern detector. Shifts one bit of x into a history
// register per clock and raises the registered strobe z for one cycle
// whenever the newest PATTERN_LEN bits equal PATTERN (MSB = oldest).
// A saturating count of valid history bits keeps bits that arrived
// before reset release, or before a full window exists, from matching.
// With OVERLAP=0 the count restarts at zero after each match, so the
// next match needs PATTERN_LEN fresh bits.
module seq_det #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(4'b1101),
    parameter bit                     OVERLAP     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    seq_det_if.slave    bus
);

    localparam int HW = PATTERN_LEN - 1;
    localparam int CW = $clog2(PATTERN_LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(PATTERN_LEN - 1);

    logic [HW-1:0]          hist_q, hist_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   z_q, z_d;
    logic [PATTERN_LEN-1:0] window;
    logic                   match;

    // Next-state: form the window, decide the match, advance history and count.
    always_comb begin
        window = {hist_q, bus.x};
        match  = (cnt_q == CNT_MAX) && (window == PATTERN);
        z_d    = match;
        hist_d = window[PATTERN_LEN-2:0];
        if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Non-overlapping mode: history is still loaded but no longer trusted.
        if (match && (OVERLAP == 1'b0)) begin
            cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            cnt_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end

    assign bus.z = z_q;

endmodule

// File: tb/tb_seq_det.sv
// Bench for seq_det. Three detectors share clk, rst and x:
//   0: 4-bit 1101, overlapping
//   1: 4-bit 1101, non-overlapping
//   2: 3-bit 111,  overlapping
// A stream-level model predicts z for each; a compare process checks
// every cycle, and directed sequences carry hand-computed z vectors.
module tb_seq_det;

    logic clk = 1'b0;
    logic rst;
    logic x;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_det_if if0 ();
    seq_det_if if1 ();
    seq_det_if if2 ();

    assign if0.x = x;
    assign if1.x = x;
    assign if2.x = x;

    seq_det #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u_def (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    seq_det #(.PATTERN_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) u_nov (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    seq_det #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1)) u_l3 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    logic [2:0] zs;
    assign zs = {if2.z, if1.z, if0.z};

    // ---------------- behavioural model ----------------
    // Each detector remembers the bits received since its last restart
    // (reset, or a match in non-overlapping mode). z is the answer to
    // "are the last L received bits, oldest first, equal to the pattern?"
    int len_a [3] = '{4, 4, 3};
    int pat_a [3] = '{13, 13, 7};
    int ov_a  [3] = '{1, 0, 1};

    bit   sb   [3][32];
    int   fill [3];
    logic [2:0] exp_z = 3'b000;

    initial begin
        for (int k = 0; k < 3; k++) fill[k] = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int k = 0; k < 3; k++) fill[k] = 0;
                exp_z = 3'b000;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    int  v;
                    bit  m;
                    if (fill[k] == 32) begin
                        for (int i = 0; i < 31; i++) sb[k][i] = sb[k][i+1];
                        fill[k] = 31;
                    end
                    sb[k][fill[k]] = x;
                    fill[k]++;
                    m = 1'b0;
                    if (fill[k] >= len_a[k]) begin
                        v = 0;
                        for (int i = 0; i < len_a[k]; i++)
                            v = (v << 1) | int'(sb[k][fill[k] - len_a[k] + i]);
                        m = (v == pat_a[k]);
                    end
                    exp_z[k] = m;
                    if (m && ov_a[k] == 0) fill[k] = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: z=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("model_def", zs[0], exp_z[0]);
            check("model_nov", zs[1], exp_z[1]);
            check("model_l3",  zs[2], exp_z[2]);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_bit(input logic b, input logic [2:0] exp, input bit pulse,
                             input string tag);
        x = b;
        if (pulse) begin
            #1 rst = 1'b0;
            #1;
            check({tag, "_async0"}, zs[0], 1'b0);
            check({tag, "_async1"}, zs[1], 1'b0);
            check({tag, "_async2"}, zs[2], 1'b0);
            #1 rst = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_def"}, zs[0], exp[0]);
        check({tag, "_nov"}, zs[1], exp[1]);
        check({tag, "_l3"},  zs[2], exp[2]);
        @(negedge clk);
    endtask

    // bits/expectations are listed first-bit-first at index n-1.
    task automatic run_seq(input string tag, input int n, input logic [15:0] bits,
                           input logic [15:0] e_def, input logic [15:0] e_nov,
                           input logic [15:0] e_l3);
        for (int i = n - 1; i >= 0; i--)
            drive_bit(bits[i], {e_l3[i], e_nov[i], e_def[i]}, 1'b0, tag);
    endtask

    // Hold reset for two cycles with x toggling; z must stay low.
    task automatic do_reset();
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x = ~x;
            @(posedge clk);
            #1;
            check("in_reset", zs[0] | zs[1] | zs[2], 1'b0);
            @(negedge clk);
        end
        rst = 1'b1;
        x   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        x   = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        do_reset();

        // Idle zeros, then the default stream 0,1,1,0,1,1,0,1.
        run_seq("idle", 4, 16'b0000, 16'b0000, 16'b0000, 16'b0000);
        run_seq("stream", 8, 16'b01101101,
                16'b00001001, 16'b00001000, 16'b00000000);

        // Near-miss 1,1,1,0,0,1,1,0,1: only the final bit completes 1101.
        do_reset();
        run_seq("partial", 9, 16'b111001101,
                16'b000000001, 16'b000000001, 16'b001000000);

        // Overlap versus restart on 1,1,0,1,1,0,1.
        do_reset();
        run_seq("overlap", 7, 16'b1101101,
                16'b0001001, 16'b0001000, 16'b0000000);

        // Async reset clears a live strobe mid-cycle.
        do_reset();
        run_seq("pre_clr", 4, 16'b1101, 16'b0001, 16'b0001, 16'b0000);
        drive_bit(1'b0, 3'b000, 1'b1, "clr_live");

        // Partial 1,1,0 discarded by a reset pulse; 1 | 1,0,1 then matches.
        do_reset();
        run_seq("mid_a", 3, 16'b110, 16'b000, 16'b000, 16'b000);
        drive_bit(1'b1, 3'b000, 1'b1, "mid_pulse");
        run_seq("mid_b", 3, 16'b101, 16'b001, 16'b001, 16'b000);

        // Self-overlapping 111: back-to-back strobes on the 3-bit detector.
        do_reset();
        run_seq("ones", 5, 16'b11111, 16'b00000, 16'b00000, 16'b00111);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
